// File: rtl/distribute1to4.sv
// Write-side 1:4 distributor: steers one accepted operand into holding slot A/B/C/D by SEL
// and tracks per-slot occupancy. Optional back-pressure build: DISTRIBUTE1TO4_STALL_EN.
module distribute1to4 #(
    parameter int N = 233
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [1:0]   SEL,
    input  logic [N-1:0] IN,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [3:0]   CONSUME,
    input  logic         CLR_OVF,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [N-1:0] C,
    output logic [N-1:0] D,
    output logic [3:0]   FULL,
    output logic         OVERFLOW
);

    // Handshake: a transfer happens at a rising CLK edge when IN_VALID & IN_READY.
    // IN_READY never looks at IN_VALID; SEL/IN only matter on a transfer.

    // Slot index equals the SEL code: 3=A, 2=B, 1=C, 0=D.
    logic [N-1:0] slot_q [4];
    logic [3:0]   full_q;
    logic [3:0]   full_d;
    logic [3:0]   wr_mask;
    logic         hit_full;
    logic         xfer;

    always_comb begin
        hit_full = full_q[SEL] & ~CONSUME[SEL];
`ifdef DISTRIBUTE1TO4_STALL_EN
        IN_READY = ~RST & ~hit_full;
`else
        IN_READY = ~RST;
`endif
        xfer    = IN_VALID & IN_READY;
        wr_mask = xfer ? (4'b0001 << SEL) : 4'b0000;
        // A write to a slot released in the same cycle keeps it full.
        full_d  = (full_q & ~CONSUME) | wr_mask;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            full_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    slot_q[i] <= IN;
                end
            end
        end
    end

`ifdef DISTRIBUTE1TO4_STALL_EN
    // Writes into an unreleased slot are stalled, so nothing can be overwritten.
    logic unused_clr_ovf;
    assign unused_clr_ovf = CLR_OVF;
    assign OVERFLOW = 1'b0;
`else
    logic ovf_q;
    logic ovf_d;

    // Sticky; a new overwrite outranks a clear in the same cycle.
    always_comb begin
        ovf_d = (xfer & hit_full) | (ovf_q & ~CLR_OVF);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVERFLOW = ovf_q;
`endif

    assign A    = slot_q[3];
    assign B    = slot_q[2];
    assign C    = slot_q[1];
    assign D    = slot_q[0];
    assign FULL = full_q;

endmodule

// File: tb/tb_distribute1to4.sv
// Self-checking bench for distribute1to4; expected slot data flows through a scoreboard queue.
module tb_distribute1to4;

    localparam int N = 233;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   sel;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   consume;
    logic         clr_ovf;
    logic [N-1:0] a_o, b_o, c_o, d_o;
    logic [3:0]   full_o;
    logic         ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] exp_q[$];
    logic [1:0]   exp_sel_q[$];

    always #5 clk = ~clk;

    distribute1to4 #(.N(N)) dut (
        .CLK(clk), .RST(rst), .SEL(sel), .IN(in_data), .IN_VALID(in_valid),
        .IN_READY(in_ready), .CONSUME(consume), .CLR_OVF(clr_ovf),
        .A(a_o), .B(b_o), .C(c_o), .D(d_o), .FULL(full_o), .OVERFLOW(ovf_o)
    );

    function automatic logic [N-1:0] slot_out(input logic [1:0] s);
        case (s)
            2'd3:    return a_o;
            2'd2:    return b_o;
            2'd1:    return c_o;
            default: return d_o;
        endcase
    endfunction

    function automatic logic [N-1:0] rand_word();
        logic [255:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[N-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; in_valid = 1'b0; consume = 4'b0000; clr_ovf = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_sel_q.delete();
    endtask

    task automatic push_write(input logic [1:0] s, input logic [N-1:0] v);
        sel = s; in_data = v; in_valid = 1'b1;
        exp_q.push_back(v);
        exp_sel_q.push_back(s);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if ({a_o, b_o, c_o, d_o} !== '0) begin
            n_fail++; $display("FAIL reset_slots: A=%h B=%h C=%h D=%h expected all 0", a_o, b_o, c_o, d_o);
        end
        n_checks++;
        if (full_o !== 4'b0000 || ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: FULL=%b OVF=%b expected 0000/0", full_o, ovf_o);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single_write();
        logic [N-1:0] v;
        v = '0;
        v[N-1] = 1'b1;
        v[3:0] = 4'h5;
        push_write(2'b11, v);
        tick();
        idle();
        begin
            logic [1:0] s; logic [N-1:0] e;
            s = exp_sel_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (slot_out(s) !== e) begin
                n_fail++; $display("FAIL single_data: slot %0d got %h expected %h", s, slot_out(s), e);
            end
        end
        n_checks++;
        if (full_o !== 4'b1000) begin
            n_fail++; $display("FAIL single_full: got %b expected 1000", full_o);
        end
        n_checks++;
        if ({b_o, c_o, d_o} !== '0) begin
            n_fail++; $display("FAIL single_others: B=%h C=%h D=%h expected 0", b_o, c_o, d_o);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push_write(2'(i), N'(i + 1));
            tick();
            begin
                logic [1:0] s; logic [N-1:0] e;
                s = exp_sel_q.pop_front(); e = exp_q.pop_front();
                n_checks++;
                if (slot_out(s) !== e) begin
                    n_fail++; $display("FAIL b2b_data: slot %0d got %h expected %h", s, slot_out(s), e);
                end
            end
        end
        idle();
        n_checks++;
        if (d_o !== N'(1) || c_o !== N'(2) || b_o !== N'(3) || a_o !== N'(4)) begin
            n_fail++; $display("FAIL b2b_final: A=%h B=%h C=%h D=%h expected 4/3/2/1", a_o, b_o, c_o, d_o);
        end
        n_checks++;
        if (full_o !== 4'b1111 || ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_flags: FULL=%b OVF=%b expected 1111/0", full_o, ovf_o);
        end
    endtask

    task automatic test_consume_write();
        apply_reset();
        push_write(2'b00, N'(5));
        tick();
        void'(exp_q.pop_front()); void'(exp_sel_q.pop_front());
        // Same-slot release and write: write wins, no overflow.
        consume = 4'b0001;
        push_write(2'b00, N'(7));
        tick();
        idle();
        begin
            logic [1:0] s; logic [N-1:0] e;
            s = exp_sel_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (slot_out(s) !== e) begin
                n_fail++; $display("FAIL cw_data: slot %0d got %h expected %h", s, slot_out(s), e);
            end
        end
        n_checks++;
        if (full_o !== 4'b0001 || ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL cw_flags: FULL=%b OVF=%b expected 0001/0", full_o, ovf_o);
        end
        // Release D while writing B.
        consume = 4'b0001;
        push_write(2'b10, N'(8'hAB));
        tick();
        idle();
        void'(exp_q.pop_front()); void'(exp_sel_q.pop_front());
        n_checks++;
        if (full_o !== 4'b0100 || b_o !== N'(8'hAB) || d_o !== N'(7)) begin
            n_fail++; $display("FAIL cw_diff: FULL=%b B=%h D=%h expected 0100/ab/7", full_o, b_o, d_o);
        end
        consume = 4'b1000;
        tick();
        idle();
        n_checks++;
        if (full_o !== 4'b0100) begin
            n_fail++; $display("FAIL consume_empty: FULL=%b expected 0100", full_o);
        end
    endtask

    task automatic test_overflow();
        push_write(2'b10, N'(9));
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ovf_ready: got %b expected 1", in_ready);
        end
        tick();
        idle();
        begin
            logic [1:0] s; logic [N-1:0] e;
            s = exp_sel_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (slot_out(s) !== e) begin
                n_fail++; $display("FAIL ovf_data: slot %0d got %h expected %h", s, slot_out(s), e);
            end
        end
        n_checks++;
        if (ovf_o !== 1'b1 || full_o !== 4'b0100) begin
            n_fail++; $display("FAIL ovf_set: OVF=%b FULL=%b expected 1/0100", ovf_o, full_o);
        end
        clr_ovf = 1'b1;
        tick();
        idle();
        n_checks++;
        if (ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf_o);
        end
        // Set and clear together: set wins.
        clr_ovf = 1'b1;
        push_write(2'b10, N'(8'h11));
        tick();
        idle();
        void'(exp_q.pop_front()); void'(exp_sel_q.pop_front());
        n_checks++;
        if (ovf_o !== 1'b1 || b_o !== N'(8'h11)) begin
            n_fail++; $display("FAIL ovf_set_wins: OVF=%b B=%h expected 1/11", ovf_o, b_o);
        end
        // A full slot released while rewritten is no overflow.
        clr_ovf = 1'b1;
        tick();
        idle();
        consume = 4'b0100;
        push_write(2'b10, N'(8'h22));
        tick();
        idle();
        void'(exp_q.pop_front()); void'(exp_sel_q.pop_front());
        n_checks++;
        if (ovf_o !== 1'b0 || full_o !== 4'b0100) begin
            n_fail++; $display("FAIL ovf_released: OVF=%b FULL=%b expected 0/0100", ovf_o, full_o);
        end
    endtask

    task automatic test_stall();
        sel = 2'b10; in_data = N'(8'h5A); in_valid = 1'b1; consume = 4'b0000; clr_ovf = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_ready: got %b expected 0", in_ready);
        end
        tick();
        n_checks++;
        if (b_o !== N'(8'hAB) || full_o !== 4'b0100 || ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: B=%h FULL=%b OVF=%b expected ab/0100/0", b_o, full_o, ovf_o);
        end
        consume = 4'b0100;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_ready: got %b expected 1", in_ready);
        end
        push_write(2'b10, N'(8'h5A));
        tick();
        idle();
        begin
            logic [1:0] s; logic [N-1:0] e;
            s = exp_sel_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (slot_out(s) !== e) begin
                n_fail++; $display("FAIL stall_data: slot %0d got %h expected %h", s, slot_out(s), e);
            end
        end
        n_checks++;
        if (full_o !== 4'b0100 || ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_flags: FULL=%b OVF=%b expected 0100/0", full_o, ovf_o);
        end
    endtask

    task automatic test_random();
        logic [3:0] m_full;
        logic [N-1:0] m_slot [4];
        logic exp_ready;
        apply_reset();
        m_full = 4'b0000;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        for (int k = 0; k < 60; k++) begin
            sel      = 2'($urandom_range(0, 3));
            in_data  = rand_word();
            in_valid = 1'($urandom_range(0, 1));
            consume  = 4'($urandom_range(0, 15));
`ifdef DISTRIBUTE1TO4_STALL_EN
            exp_ready = ~(m_full[sel] & ~consume[sel]);
`else
            exp_ready = 1'b1;
`endif
            #1;
            n_checks++;
            if (in_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", k, in_ready, exp_ready);
            end
            m_full = m_full & ~consume;
            if (in_valid && exp_ready) begin
                exp_q.push_back(in_data);
                exp_sel_q.push_back(sel);
                m_full[sel] = 1'b1;
                m_slot[sel] = in_data;
            end
            tick();
            while (exp_q.size() > 0) begin
                logic [1:0] s; logic [N-1:0] e;
                s = exp_sel_q.pop_front(); e = exp_q.pop_front();
                n_checks++;
                if (slot_out(s) !== e) begin
                    n_fail++; $display("FAIL rand_data[%0d]: slot %0d got %h expected %h", k, s, slot_out(s), e);
                end
            end
            n_checks++;
            if (full_o !== m_full) begin
                n_fail++; $display("FAIL rand_full[%0d]: got %b expected %b", k, full_o, m_full);
            end
        end
        idle();
        n_checks++;
        if (a_o !== m_slot[3] || b_o !== m_slot[2] || c_o !== m_slot[1] || d_o !== m_slot[0]) begin
            n_fail++; $display("FAIL rand_held: slot contents differ from last writes");
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i); in_data = N'(16'h100 + i); in_valid = 1'b1;
            tick();
        end
`ifndef DISTRIBUTE1TO4_STALL_EN
        sel = 2'b11; in_data = N'(16'h1FF); in_valid = 1'b1;
        tick();
`endif
        rst = 1'b1; sel = 2'b11; in_data = N'(8'h3C); in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_ready: got %b expected 0", in_ready);
        end
        tick();
        n_checks++;
        if ({a_o, b_o, c_o, d_o} !== '0 || full_o !== 4'b0000 || ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: A=%h FULL=%b OVF=%b expected 0/0000/0", a_o, full_o, ovf_o);
        end
        idle();
        tick();
        n_checks++;
        if (a_o !== '0 || full_o !== 4'b0000) begin
            n_fail++; $display("FAIL mid_reset_drop: A=%h FULL=%b expected 0/0000", a_o, full_o);
        end
    endtask

    initial begin
        rst = 1'b1; sel = 2'b00; in_data = '0; in_valid = 1'b0; consume = 4'b0000; clr_ovf = 1'b0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_consume_write();
`ifdef DISTRIBUTE1TO4_STALL_EN
        test_stall();
`else
        test_overflow();
`endif
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
